// File: rtl/vga_timing_pkg.sv
// Shared timing definitions for the raster generator: video mode
// parameter sets and a counter-width helper used for geometry checks.
package vga_timing_pkg;

  // One complete video mode. Horizontal fields are in pixel clocks,
  // vertical fields are in lines. A polarity of 1 means the sync
  // pulse is driven high.
  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
    logic        h_pol;
    logic        v_pol;
    int unsigned pixel_khz;
  } vga_mode_t;

  // 800x600 @ 60 Hz, 1056x628 total, 40 MHz pixel clock.
  localparam vga_mode_t SVGA_800x600_60 = '{
    h_active : 800, h_fp : 40, h_sync : 128, h_bp : 88,
    v_active : 600, v_fp : 1,  v_sync : 4,   v_bp : 23,
    h_pol    : 1'b1, v_pol : 1'b1,
    pixel_khz: 40000
  };

  // 640x480 @ 60 Hz, 800x525 total, 25.175 MHz pixel clock.
  localparam vga_mode_t VGA_640x480_60 = '{
    h_active : 640, h_fp : 16, h_sync : 96, h_bp : 48,
    v_active : 480, v_fp : 10, v_sync : 2,  v_bp : 33,
    h_pol    : 1'b0, v_pol : 1'b0,
    pixel_khz: 25175
  };

  // Smallest width (at least 1) whose range 0..2**w-1 holds n distinct
  // values, i.e. the counter width needed to count 0..n-1.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((w < 31) && ((1 << w) < n)) begin
      w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter with step enable, plus
// region decode of the position it will hold after the coming edge.
// Decoding the next position lets the parent register its outputs in
// the same edge as the counter, so nothing lags the coordinates.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = 800,
  parameter int FP     = 40,
  parameter int SYNC   = 128,
  parameter int BP     = 88,
  parameter int CW     = 11
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          step,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_nxt,
  output logic          wrap,
  output logic          blank_nxt,
  output logic          sync_nxt
);

  localparam int TOTAL = ACTIVE + FP + SYNC + BP;

  // Every region must exist and the whole line/frame must fit the counter.
  if ((ACTIVE <= 0) || (FP <= 0) || (SYNC <= 0) || (BP <= 0)) begin : g_bad_region
    $error("vga_axis_counter: every region (ACTIVE, FP, SYNC, BP) must be non-zero");
  end
  if (cnt_width(TOTAL) > CW) begin : g_bad_width
    $error("vga_axis_counter: TOTAL exceeds 2**CW");
  end

  // Region boundaries. SYNC_END is exclusive; it is below TOTAL because
  // the back porch is at least one step, so it always fits in CW bits.
  localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACTIVE_END = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_START = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_END   = CW'(ACTIVE + FP + SYNC);

  // Wrap fires only on a real step out of the last position.
  assign wrap = step && (count == LAST);

  // Next position and the regions it falls in.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path
    // leaves it unassigned; that is what keeps a latch from being inferred.
    count_nxt = count;
    if (step) begin
      count_nxt = wrap ? '0 : count + CW'(1);
    end
    blank_nxt = (count_nxt >= ACTIVE_END);
    sync_nxt  = (count_nxt >= SYNC_START) && (count_nxt < SYNC_END);
  end

  // Position register; resets to the last position so the first step
  // after reset lands on 0.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every
    // flop samples pre-edge values regardless of block ordering.
    if (!rst_n) begin
      count <= LAST;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator in the pixel-clock domain.
// Produces sync, blanking, data-enable, coordinates, a frame-start
// strobe and a programmable line-compare strobe, all registered and
// aligned to the same edge as the coordinates.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = SVGA_800x600_60.h_active,
  parameter int   H_FP     = SVGA_800x600_60.h_fp,
  parameter int   H_SYNC   = SVGA_800x600_60.h_sync,
  parameter int   H_BP     = SVGA_800x600_60.h_bp,
  parameter int   V_ACTIVE = SVGA_800x600_60.v_active,
  parameter int   V_FP     = SVGA_800x600_60.v_fp,
  parameter int   V_SYNC   = SVGA_800x600_60.v_sync,
  parameter int   V_BP     = SVGA_800x600_60.v_bp,
  parameter logic H_POL    = SVGA_800x600_60.h_pol,
  parameter logic V_POL    = SVGA_800x600_60.v_pol,
  parameter int   CW       = 11
) (
  input  logic          clk_pixel,
  input  logic          rst_n,
  input  logic          en,
  input  logic [CW-1:0] line_cmp,
  output logic          hsync,
  output logic          vsync,
  output logic          hblank,
  output logic          vblank,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          frame_start,
  output logic          line_match
);

  logic          h_wrap;
  logic          h_blank_nxt;
  logic          h_sync_nxt;
  logic [CW-1:0] h_nxt_unused;
  logic          v_wrap;
  logic          v_blank_nxt;
  logic          v_sync_nxt;
  logic [CW-1:0] v_nxt;

  // Horizontal axis steps on every enabled clock.
  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .CW     (CW)
  ) u_h (
    .clk       (clk_pixel),
    .rst_n     (rst_n),
    .step      (en),
    .count     (x),
    .count_nxt (h_nxt_unused),
    .wrap      (h_wrap),
    .blank_nxt (h_blank_nxt),
    .sync_nxt  (h_sync_nxt)
  );

  // Vertical axis steps only when the line wraps, so vsync can only
  // change at x==0 boundaries.
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .CW     (CW)
  ) u_v (
    .clk       (clk_pixel),
    .rst_n     (rst_n),
    .step      (h_wrap),
    .count     (y),
    .count_nxt (v_nxt),
    .wrap      (v_wrap),
    .blank_nxt (v_blank_nxt),
    .sync_nxt  (v_sync_nxt)
  );

  // Output levels and strobes, registered from the next position so they
  // change on the same edge as x/y. With en low the next position equals
  // the current one, so levels hold and both wraps (hence strobes) are 0.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= ~H_POL;
      vsync       <= ~V_POL;
      hblank      <= 1'b1;
      vblank      <= 1'b1;
      de          <= 1'b0;
      frame_start <= 1'b0;
      line_match  <= 1'b0;
    end else begin
      hsync       <= h_sync_nxt ? H_POL : ~H_POL;
      vsync       <= v_sync_nxt ? V_POL : ~V_POL;
      hblank      <= h_blank_nxt;
      vblank      <= v_blank_nxt;
      de          <= ~h_blank_nxt & ~v_blank_nxt;
      frame_start <= h_wrap & v_wrap;
      // v_nxt never exceeds V_TOTAL-1, so out-of-range compares never hit.
      line_match  <= h_wrap & (v_nxt == line_cmp);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed self-checking bench for vga_timing_gen. Three instances share
// one clock: default 800x600 geometry, a scaled-down 24x18 geometry for
// whole-frame checks, and a tiny 8x6 geometry checked exhaustively.
module tb_vga_timing_gen;

  int tests = 0;
  int fails = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default geometry: 1056 x 628.
  logic        rst_n, en;
  logic [10:0] line_cmp;
  logic        hsync, vsync, hblank, vblank, de, frame_start, line_match;
  logic [10:0] x, y;

  vga_timing_gen u_dut (
    .clk_pixel   (clk),
    .rst_n       (rst_n),
    .en          (en),
    .line_cmp    (line_cmp),
    .hsync       (hsync),
    .vsync       (vsync),
    .hblank      (hblank),
    .vblank      (vblank),
    .de          (de),
    .x           (x),
    .y           (y),
    .frame_start (frame_start),
    .line_match  (line_match)
  );

  // Mid geometry: H 16/2/4/2 = 24, V 12/1/2/3 = 18, active-high syncs.
  logic       m_rst_n, m_en;
  logic [5:0] m_line_cmp;
  logic       m_hsync, m_vsync, m_hblank, m_vblank, m_de, m_fs, m_lm;
  logic [5:0] m_x, m_y;

  vga_timing_gen #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (2),
    .V_ACTIVE (12), .V_FP (1), .V_SYNC (2), .V_BP (3),
    .H_POL (1'b1), .V_POL (1'b1), .CW (6)
  ) u_mid (
    .clk_pixel   (clk),
    .rst_n       (m_rst_n),
    .en          (m_en),
    .line_cmp    (m_line_cmp),
    .hsync       (m_hsync),
    .vsync       (m_vsync),
    .hblank      (m_hblank),
    .vblank      (m_vblank),
    .de          (m_de),
    .x           (m_x),
    .y           (m_y),
    .frame_start (m_fs),
    .line_match  (m_lm)
  );

  // Tiny geometry: H 4/1/2/1 = 8, V 3/1/1/1 = 6, active-low syncs.
  logic       t_rst_n, t_en;
  logic [3:0] t_line_cmp;
  logic       t_hsync, t_vsync, t_hblank, t_vblank, t_de, t_fs, t_lm;
  logic [3:0] t_x, t_y;

  vga_timing_gen #(
    .H_ACTIVE (4), .H_FP (1), .H_SYNC (2), .H_BP (1),
    .V_ACTIVE (3), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .H_POL (1'b0), .V_POL (1'b0), .CW (4)
  ) u_tiny (
    .clk_pixel   (clk),
    .rst_n       (t_rst_n),
    .en          (t_en),
    .line_cmp    (t_line_cmp),
    .hsync       (t_hsync),
    .vsync       (t_vsync),
    .hblank      (t_hblank),
    .vblank      (t_vblank),
    .de          (t_de),
    .x           (t_x),
    .y           (t_y),
    .frame_start (t_fs),
    .line_match  (t_lm)
  );

  // Strobe counts accumulated while bulk-advancing the default instance.
  int d_fs_cnt;
  int d_lm_cnt;

  // Advance n clocks; returns 1 time unit after the last rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance the default instance n clocks, counting its strobes.
  task automatic adv(input int n);
    repeat (n) begin
      tick(1);
      if (frame_start === 1'b1) d_fs_cnt++;
      if (line_match === 1'b1)  d_lm_cnt++;
    end
  endtask

  // Packed view of the default instance: {x,y,hs,vs,hb,vb,de,fs,lm}.
  function automatic logic [28:0] d_vec();
    return {x, y, hsync, vsync, hblank, vblank, de, frame_start, line_match};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; line_cmp = 11'd10;
    tick(3);
    tests++;
    if (d_vec() !== {11'd1055, 11'd627, 7'b0011000}) begin
      fails++;
      $display("FAIL reset_state: got %h want %h", d_vec(), {11'd1055, 11'd627, 7'b0011000});
    end
    rst_n = 1'b1;
    tick(1);
    tests++;
    if (d_vec() !== {11'd0, 11'd0, 7'b0000110}) begin
      fails++;
      $display("FAIL first_edge: got %h want %h", d_vec(), {11'd0, 11'd0, 7'b0000110});
    end
    tick(1);
    tests++;
    if ((x !== 11'd1) || (y !== 11'd0) || (frame_start !== 1'b0)) begin
      fails++;
      $display("FAIL second_edge: got x=%0d y=%0d fs=%b want 1 0 0", x, y, frame_start);
    end
  endtask

  task automatic test_hsync();
    int w;
    tick(838);  // (1,0) -> (839,0)
    tests++;
    if ((x !== 11'd839) || (hsync !== 1'b0) || (hblank !== 1'b1)) begin
      fails++;
      $display("FAIL hsync_pre: got x=%0d hs=%b hb=%b want 839 0 1", x, hsync, hblank);
    end
    tick(1);
    tests++;
    if ((x !== 11'd840) || (hsync !== 1'b1)) begin
      fails++;
      $display("FAIL hsync_start: got x=%0d hs=%b want 840 1", x, hsync);
    end
    w = 1;
    while ((hsync === 1'b1) && (w < 300)) begin
      tick(1);
      if (hsync === 1'b1) w++;
    end
    tests++;
    if ((w !== 128) || (x !== 11'd968)) begin
      fails++;
      $display("FAIL hsync_width: got width=%0d end_x=%0d want 128 968", w, x);
    end
  endtask

  task automatic test_en_hold();
    d_fs_cnt = 0;
    d_lm_cnt = 0;
    adv(10391);  // (968,0) -> (799,10), passing (0,10) once
    tests++;
    if ((d_vec() !== {11'd799, 11'd10, 7'b0000100}) || (d_lm_cnt !== 1) || (d_fs_cnt !== 0)) begin
      fails++;
      $display("FAIL run_to_799_10: got %h lm=%0d fs=%0d want %h 1 0",
               d_vec(), d_lm_cnt, d_fs_cnt, {11'd799, 11'd10, 7'b0000100});
    end
    en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      tests++;
      if (d_vec() !== {11'd799, 11'd10, 7'b0000100}) begin
        fails++;
        $display("FAIL en_hold[%0d]: got %h want %h", i, d_vec(), {11'd799, 11'd10, 7'b0000100});
      end
    end
    en = 1'b1;
    tick(1);
    tests++;
    if (d_vec() !== {11'd800, 11'd10, 7'b0010000}) begin
      fails++;
      $display("FAIL en_resume: got %h want %h", d_vec(), {11'd800, 11'd10, 7'b0010000});
    end
  endtask

  task automatic test_async_reset();
    adv(556);  // (800,10) -> (300,11)
    tests++;
    if ((x !== 11'd300) || (y !== 11'd11) || (de !== 1'b1)) begin
      fails++;
      $display("FAIL pre_reset_pos: got x=%0d y=%0d de=%b want 300 11 1", x, y, de);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (d_vec() !== {11'd1055, 11'd627, 7'b0011000}) begin
      fails++;
      $display("FAIL async_snap: got %h want %h", d_vec(), {11'd1055, 11'd627, 7'b0011000});
    end
    tick(3);
    tests++;
    if (d_vec() !== {11'd1055, 11'd627, 7'b0011000}) begin
      fails++;
      $display("FAIL async_hold: got %h want %h", d_vec(), {11'd1055, 11'd627, 7'b0011000});
    end
    rst_n = 1'b1;
    tick(1);
    tests++;
    if (d_vec() !== {11'd0, 11'd0, 7'b0000110}) begin
      fails++;
      $display("FAIL async_restart: got %h want %h", d_vec(), {11'd0, 11'd0, 7'b0000110});
    end
  endtask

  task automatic test_mid_frames();
    int fs_c[4];
    int n_fs;
    int hs_rise[2], hs_high[2], vs_high[2], de_cnt[2], lm_cnt[2];
    int bad_rise, bad_lm, vs_first_x, vs_first_y, vs_last_y;
    logic prev_hs;
    int f;
    n_fs = 0; bad_rise = 0; bad_lm = 0;
    vs_first_x = -1; vs_first_y = -1; vs_last_y = -1;
    for (int i = 0; i < 2; i++) begin
      hs_rise[i] = 0; hs_high[i] = 0; vs_high[i] = 0; de_cnt[i] = 0; lm_cnt[i] = 0;
    end
    m_en = 1'b1; m_line_cmp = 6'd11;
    m_rst_n = 1'b1;
    prev_hs = 1'b0;
    for (int c = 1; c <= 865; c++) begin
      tick(1);
      if (m_fs === 1'b1) begin
        if (n_fs < 4) fs_c[n_fs] = c;
        n_fs++;
      end
      if (c <= 864) begin
        f = (c - 1) / 432;
        if ((m_hsync === 1'b1) && (prev_hs === 1'b0)) begin
          hs_rise[f]++;
          if (m_x !== 6'd18) bad_rise++;
        end
        if (m_hsync === 1'b1) hs_high[f]++;
        if (m_vsync === 1'b1) begin
          vs_high[f]++;
          if (vs_first_y < 0) begin
            vs_first_x = int'(m_x);
            vs_first_y = int'(m_y);
          end
          if (f == 0) vs_last_y = int'(m_y);
        end
        if (m_de === 1'b1) de_cnt[f]++;
        if (m_lm === 1'b1) begin
          lm_cnt[f]++;
          if ((m_x !== 6'd0) || (m_y !== 6'd11)) bad_lm++;
        end
      end
      prev_hs = m_hsync;
    end
    tests++;
    if ((n_fs !== 3) || (fs_c[0] !== 1) || (fs_c[1] - fs_c[0] !== 432) || (fs_c[2] - fs_c[1] !== 432)) begin
      fails++;
      $display("FAIL mid_frame_period: got n=%0d at %0d,%0d,%0d want 3 at 1,433,865",
               n_fs, fs_c[0], fs_c[1], fs_c[2]);
    end
    for (int i = 0; i < 2; i++) begin
      tests++;
      if ((hs_rise[i] !== 18) || (hs_high[i] !== 72) || (vs_high[i] !== 48) ||
          (de_cnt[i] !== 192) || (lm_cnt[i] !== 1)) begin
        fails++;
        $display("FAIL mid_frame_counts[%0d]: got hs=%0d hs_clk=%0d vs_clk=%0d de=%0d lm=%0d want 18 72 48 192 1",
                 i, hs_rise[i], hs_high[i], vs_high[i], de_cnt[i], lm_cnt[i]);
      end
    end
    tests++;
    if ((bad_rise !== 0) || (bad_lm !== 0)) begin
      fails++;
      $display("FAIL mid_positions: got bad_hsync_start=%0d bad_line_match=%0d want 0 0", bad_rise, bad_lm);
    end
    tests++;
    if ((vs_first_x !== 0) || (vs_first_y !== 13) || (vs_last_y !== 14)) begin
      fails++;
      $display("FAIL mid_vsync_lines: got start=(%0d,%0d) last_y=%0d want (0,13) 14",
               vs_first_x, vs_first_y, vs_last_y);
    end
  endtask

  task automatic test_mid_line_cmp();
    int cnt;
    m_line_cmp = 6'd20;  // beyond V_TOTAL-1 = 17
    cnt = 0;
    for (int c = 0; c < 432; c++) begin
      tick(1);
      if (m_lm === 1'b1) cnt++;
    end
    tests++;
    if (cnt !== 0) begin
      fails++;
      $display("FAIL mid_cmp_out_of_range: got %0d pulses want 0", cnt);
    end
    m_line_cmp = 6'd17;  // last line of the frame
    cnt = 0;
    for (int c = 0; c < 432; c++) begin
      tick(1);
      if (m_lm === 1'b1) begin
        cnt++;
        if (m_y !== 6'd17) cnt += 100;
      end
    end
    tests++;
    if (cnt !== 1) begin
      fails++;
      $display("FAIL mid_cmp_last_line: got %0d want 1", cnt);
    end
  endtask

  task automatic test_tiny_exhaustive();
    int tx, ty, err, de_cnt[3];
    logic [14:0] got, exp_v;
    logic hs_e, vs_e, hb_e, vb_e, fs_e, lm_e;
    t_en = 1'b1; t_line_cmp = 4'd2;
    tests++;
    got = {t_x, t_y, t_hsync, t_vsync, t_hblank, t_vblank, t_de, t_fs, t_lm};
    if (got !== {4'd7, 4'd5, 7'b1111000}) begin
      fails++;
      $display("FAIL tiny_reset: got %h want %h", got, {4'd7, 4'd5, 7'b1111000});
    end
    t_rst_n = 1'b1;
    tx = 7; ty = 5; err = 0;
    for (int i = 0; i < 3; i++) de_cnt[i] = 0;
    for (int c = 0; c < 144; c++) begin
      tick(1);
      fs_e = (tx == 7) && (ty == 5);
      if (tx == 7) begin
        tx = 0;
        ty = (ty == 5) ? 0 : ty + 1;
      end else begin
        tx = tx + 1;
      end
      hs_e = !((tx == 5) || (tx == 6));
      vs_e = (ty != 4);
      hb_e = (tx >= 4);
      vb_e = (ty >= 3);
      lm_e = (tx == 0) && (ty == 2);
      exp_v = {4'(tx), 4'(ty), hs_e, vs_e, hb_e, vb_e, !hb_e && !vb_e, fs_e, lm_e};
      got = {t_x, t_y, t_hsync, t_vsync, t_hblank, t_vblank, t_de, t_fs, t_lm};
      if (t_de === 1'b1) de_cnt[c / 48]++;
      tests++;
      if (got !== exp_v) begin
        fails++;
        err++;
        if (err <= 10) $display("FAIL tiny_cycle[%0d]: got %h want %h", c, got, exp_v);
      end
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (de_cnt[i] !== 12) begin
        fails++;
        $display("FAIL tiny_de_count[%0d]: got %0d want 12", i, de_cnt[i]);
      end
    end
  endtask

  initial begin
    m_rst_n = 1'b0; m_en = 1'b0; m_line_cmp = '0;
    t_rst_n = 1'b0; t_en = 1'b0; t_line_cmp = '0;
    test_reset();
    test_hsync();
    test_en_hold();
    test_async_reset();
    test_mid_frames();
    test_mid_line_cmp();
    test_tiny_exhaustive();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
